// File: rtl/pps_gen_sync.sv
// Local 1PPS generator: divides CLK_SYS with signed integer + fractional period
// compensation, aligns to GPS 1PPS, measures phase error and falls back to holdover.
module pps_gen_sync #(
    parameter int unsigned CNT_W        = 28,
    parameter int unsigned PERIOD       = 10_000_000,
    parameter int unsigned PULSE        = 1_000_000,
    parameter int unsigned COMP_W       = 25,
    parameter int unsigned FRAC_W       = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned LOSS_TIMEOUT = 2
) (
    input  logic                CLK_SYS,
    input  logic                CLK_RST,
    input  logic                pps_gps,
    input  logic [1:0]          mode,
    input  logic [COMP_W-1:0]   comp_int,
    input  logic [FRAC_W-1:0]   comp_frac,
    input  logic                comp_valid,
    output logic                pps_local,
    output logic                period_tick,
    output logic [CNT_W-1:0]    phase_err,
    output logic                phase_valid,
    output logic                holdover,
    output logic [1:0]          state
);
    localparam int unsigned TW     = CNT_W + 2;
    localparam int unsigned MISS_W = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = {2'b00, {CNT_W{1'b1}}};
    localparam logic [1:0] MODE_FREE   = 2'b00;
    localparam logic [1:0] MODE_ALWAYS = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   gps_dly_q;
    logic                   gps_rise_c;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FRAC_W-1:0]        acc_q, acc_d;
    logic                     carry_q, carry_d;
    logic signed [COMP_W-1:0] sh_int_q, sh_int_d;
    logic [FRAC_W-1:0]        sh_frac_q, sh_frac_d;
    logic signed [COMP_W-1:0] act_int_q, act_int_d;
    logic [FRAC_W-1:0]        act_frac_q, act_frac_d;
    logic                     pps_q, pps_d;
    logic                     tick_q, tick_d;
    logic [CNT_W-1:0]         perr_q, perr_d;
    logic                     pvalid_q, pvalid_d;
    logic                     hold_q, hold_d;
    logic [MISS_W-1:0]        missed_q, missed_d;
    logic                     seen_q, seen_d;

    logic signed [TW-1:0] t_raw_c;
    logic [CNT_W-1:0]     t_c;
    logic [CNT_W:0]       half_c;
    logic                 wrap_c, align_c, boundary_c, meas_c, miss_c, timeout_c;
    logic [MISS_W-1:0]    missed_inc_c;

    // GPS input synchroniser and rising-edge detect
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            sync_q    <= '0;
            gps_dly_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pps_gps};
            gps_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign gps_rise_c = sync_q[SYNC_STAGES-1] & ~gps_dly_q;

    // Terminal count of the running period, clamped so the pulse always fits
    always_comb begin
        t_raw_c = $signed(TW'(PERIOD)) + TW'(act_int_q) + $signed(TW'(carry_q)) - $signed(TW'(1));
        if (t_raw_c < $signed(TW'(PULSE))) begin
            t_c = CNT_W'(PULSE);
        end else if (t_raw_c > $signed(T_MAX)) begin
            t_c = '1;
        end else begin
            t_c = t_raw_c[CNT_W-1:0];
        end
        half_c = ({1'b0, t_c} + (CNT_W+1)'(1)) >> 1;
    end

    // Event decode shared by the FSM and the datapath
    always_comb begin
        wrap_c  = (state_q != ST_WAIT) && (cnt_q == t_c);
        align_c = 1'b0;
        case (state_q)
            ST_WAIT: align_c = (mode == MODE_FREE) || gps_rise_c;
            ST_RUN:  align_c = gps_rise_c && (mode == MODE_ALWAYS);
            ST_HOLD: align_c = gps_rise_c && (mode != MODE_FREE);
            default: align_c = 1'b0;
        endcase
        boundary_c   = wrap_c || align_c;
        meas_c       = gps_rise_c && (state_q != ST_WAIT);
        miss_c       = (state_q == ST_RUN) && wrap_c && !gps_rise_c && !seen_q;
        missed_inc_c = missed_q + MISS_W'(1);
        timeout_c    = miss_c && (missed_inc_c >= MISS_W'(LOSS_TIMEOUT));
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) state_q <= ST_WAIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (boundary_c) state_d = ST_RUN;
            ST_RUN:  if (timeout_c)  state_d = ST_HOLD;
            ST_HOLD: if (gps_rise_c) state_d = ST_RUN;
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        cnt_d      = (state_q == ST_WAIT) ? '0 : cnt_q + CNT_W'(1);
        acc_d      = acc_q;
        carry_d    = carry_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        pps_d      = pps_q;
        tick_d     = boundary_c;
        perr_d     = perr_q;
        pvalid_d   = meas_c;
        hold_d     = (state_d == ST_HOLD);
        missed_d   = missed_q;
        seen_d     = boundary_c ? 1'b0 : (seen_q | gps_rise_c);

        // New carry is taken from the compensation that was active in the ending period
        if (boundary_c) begin
            cnt_d              = '0;
            pps_d              = 1'b1;
            act_int_d          = sh_int_q;
            act_frac_d         = sh_frac_q;
            {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, act_frac_q};
        end else if (cnt_q == CNT_W'(PULSE - 1)) begin
            pps_d = 1'b0;
        end

        if (comp_valid) begin
            sh_int_d  = $signed(comp_int);
            sh_frac_d = comp_frac;
        end

        if (meas_c) begin
            perr_d = ({1'b0, cnt_q} >= half_c) ? cnt_q - t_c : cnt_q + CNT_W'(1);
        end

        if ((state_q != ST_RUN) || gps_rise_c) begin
            missed_d = '0;
        end else if (miss_c) begin
            missed_d = missed_inc_c;
        end
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            sh_int_q   <= '0;
            sh_frac_q  <= '0;
            act_int_q  <= '0;
            act_frac_q <= '0;
            pps_q      <= 1'b0;
            tick_q     <= 1'b0;
            perr_q     <= '0;
            pvalid_q   <= 1'b0;
            hold_q     <= 1'b0;
            missed_q   <= '0;
            seen_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            pps_q      <= pps_d;
            tick_q     <= tick_d;
            perr_q     <= perr_d;
            pvalid_q   <= pvalid_d;
            hold_q     <= hold_d;
            missed_q   <= missed_d;
            seen_q     <= seen_d;
        end
    end

    assign pps_local   = pps_q;
    assign period_tick = tick_q;
    assign phase_err   = perr_q;
    assign phase_valid = pvalid_q;
    assign holdover    = hold_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pps_gen_sync.sv
// Randomized bench for pps_gen_sync against a time-stamp based model of the
// local PPS (period start times and lengths rather than a counter).
module tb_pps_gen_sync;
    localparam int unsigned CNT_W  = 28;
    localparam int unsigned PERIOD = 100;
    localparam int unsigned PULSE  = 10;
    localparam int unsigned COMP_W = 25;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned LOSS   = 2;
    localparam int GPS_HIGH = 5;

    logic              CLK_SYS = 1'b0;
    logic              CLK_RST = 1'b0;
    logic              pps_gps = 1'b0;
    logic [1:0]        mode = 2'b01;
    logic [COMP_W-1:0] comp_int = '0;
    logic [FRAC_W-1:0] comp_frac = '0;
    logic              comp_valid = 1'b0;
    logic              pps_local, period_tick, phase_valid, holdover;
    logic [CNT_W-1:0]  phase_err;
    logic [1:0]        state;

    pps_gen_sync #(
        .CNT_W(CNT_W), .PERIOD(PERIOD), .PULSE(PULSE), .COMP_W(COMP_W),
        .FRAC_W(FRAC_W), .SYNC_STAGES(SYNC), .LOSS_TIMEOUT(LOSS)
    ) dut (
        .CLK_SYS(CLK_SYS), .CLK_RST(CLK_RST), .pps_gps(pps_gps), .mode(mode),
        .comp_int(comp_int), .comp_frac(comp_frac), .comp_valid(comp_valid),
        .pps_local(pps_local), .period_tick(period_tick), .phase_err(phase_err),
        .phase_valid(phase_valid), .holdover(holdover), .state(state)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: period described by its start edge index and its length
    int     hist[SYNC+1];
    int     m_st, cyc, t0, last_rise, missed;
    int     ai, af, si, sf, acc, carry;
    longint len, m_pe;
    bit     m_pv, m_tick;

    function automatic longint calc_len(input int a_int, input int c);
        longint l;
        l = longint'(PERIOD) + a_int + c;
        if (l < longint'(PULSE) + 1) l = longint'(PULSE) + 1;
        if (l > (longint'(1) << CNT_W)) l = longint'(1) << CNT_W;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= SYNC; i++) hist[i] = 0;
        m_st = 0; cyc = 0; t0 = 0; last_rise = -1; missed = 0;
        ai = 0; af = 0; si = 0; sf = 0; acc = 0; carry = 0;
        len = calc_len(0, 0); m_pe = 0; m_pv = 0; m_tick = 0;
    endtask

    task automatic model_step();
        bit     rise, wrap, align, bnd;
        int     md, nst;
        longint el;
        rise = (hist[SYNC-1] != 0) && (hist[SYNC] == 0);
        for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(pps_gps);
        md   = int'(mode);
        el   = longint'(cyc - t0);
        wrap = (m_st != 0) && (el == len - 1);
        case (m_st)
            0:       align = (md == 0) || rise;
            1:       align = rise && (md == 2);
            default: align = rise && (md != 0);
        endcase
        bnd  = wrap || align;
        m_pv = 1'b0;
        if (m_st != 0 && rise) begin
            m_pv = 1'b1;
            m_pe = (el >= len / 2) ? el - (len - 1) : el + 1;
        end
        nst = m_st;
        case (m_st)
            0: if (bnd) nst = 1;
            1: begin
                if (rise) missed = 0;
                else if (wrap && !(last_rise > t0)) begin
                    missed++;
                    if (missed >= int'(LOSS)) begin nst = 2; missed = 0; end
                end
            end
            default: if (rise) begin nst = 1; missed = 0; end
        endcase
        m_st = nst;
        cyc++;
        if (rise) last_rise = cyc;
        if (bnd) begin
            t0    = cyc;
            acc   = acc + af;
            carry = acc >> FRAC_W;
            acc   = acc % (1 << FRAC_W);
            ai    = si;
            af    = sf;
            len   = calc_len(ai, carry);
        end
        m_tick = bnd;
        if (comp_valid) begin
            si = int'($signed(comp_int));
            sf = int'(comp_frac);
        end
    endtask

    task automatic do_checks();
        check("pps_local",   pps_local,          (m_st != 0) && (cyc - t0 < int'(PULSE)));
        check("period_tick", period_tick,        m_tick);
        check("phase_valid", phase_valid,        m_pv);
        check("phase_err",   $signed(phase_err), m_pe);
        check("holdover",    holdover,           m_st == 2);
        check("state",       state,              m_st);
    endtask

    // Stimulus state
    int gps_per = 100, gps_ph = 0, gps_hold = 0;
    bit gps_en = 0, rand_comp = 0;
    int req_int[$];
    int req_frac[$];

    task automatic push_comp(input int ci, input int cf);
        req_int.push_back(ci);
        req_frac.push_back(cf);
    endtask

    task automatic drive_next();
        int r;
        comp_valid = 1'b0;
        if (req_int.size() > 0) begin
            comp_valid = 1'b1;
            comp_int   = COMP_W'(req_int.pop_front());
            comp_frac  = FRAC_W'(req_frac.pop_front());
        end else if (rand_comp && $urandom_range(0, 149) == 0) begin
            r          = int'($urandom_range(0, 6)) - 3;
            comp_valid = 1'b1;
            comp_int   = COMP_W'(r);
            comp_frac  = FRAC_W'($urandom_range(0, 255));
        end
        if (gps_hold > 0) gps_hold--;
        else gps_ph = (gps_ph + 1) % gps_per;
        pps_gps = gps_en && (gps_ph < GPS_HIGH);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge CLK_SYS);
            model_step();
            #1;
            do_checks();
            drive_next();
        end
    endtask

    task automatic apply_reset();
        CLK_RST    = 1'b0;
        gps_en     = 1'b0;
        pps_gps    = 1'b0;
        comp_valid = 1'b0;
        gps_ph     = 0;
        #1;
        check("rst_pps_local",   pps_local,   0);
        check("rst_state",       state,       0);
        check("rst_holdover",    holdover,    0);
        check("rst_phase_valid", phase_valid, 0);
        check("rst_phase_err",   $signed(phase_err), 0);
        repeat (3) @(posedge CLK_SYS);
        #1;
        CLK_RST = 1'b1;
        model_reset();
        do_checks();
    endtask

    initial begin
        int waited;
        model_reset();
        repeat (3) @(posedge CLK_SYS);
        #1;
        CLK_RST = 1'b1;
        do_checks();

        // Align once, then integer compensation and clamping
        mode = 2'b01; gps_en = 1; gps_per = 100;
        run(450);
        push_comp(5, 0);    run(600);
        push_comp(-95, 0);  run(150);
        push_comp(0, 0);    run(300);

        // Fractional compensation: one long period out of four
        push_comp(0, 8'h40); run(1000);
        push_comp(0, 0);     run(400);

        // GPS late by 3 cycles: measure only, then realign in ALIGN_ALWAYS
        gps_hold = 3; run(300);
        mode = 2'b10; gps_hold = 3; run(300);

        // Loss of GPS, holdover, recovery with realign
        gps_en = 0; run(500);
        mode = 2'b01; gps_en = 1; run(400);

        // Back-to-back strobes: last one wins
        push_comp(7, 0); push_comp(-2, 0); run(500);
        push_comp(0, 0); run(200);

        // Reset in the middle of a pulse, no pulse until GPS returns
        waited = 0;
        while (!(m_st != 0 && (cyc - t0) > 2 && (cyc - t0) < int'(PULSE)) && waited < 300) begin
            run(1);
            waited++;
        end
        check("reach_mid_pulse", waited < 300, 1);
        apply_reset();
        run(200);
        gps_en = 1; run(300);

        // Free-running start straight out of reset
        mode = 2'b00;
        apply_reset();
        run(300);

        // Randomized segments
        rand_comp = 1;
        for (int seg = 0; seg < 25; seg++) begin
            mode    = 2'($urandom_range(0, 3));
            gps_per = int'($urandom_range(97, 103));
            gps_ph  = gps_ph % gps_per;
            gps_en  = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) gps_hold = int'($urandom_range(1, 20));
            run(int'($urandom_range(200, 700)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
